// File: rtl/rmul_pkg.sv
// Shared types and helpers for the sequential recursive multiplier.
// Latency: n/a (declarations only). Backpressure: n/a.
// Used by rmul_half_core and recursive_mult_seq (optional RMUL_ERR_DIST_EN).
package rmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LL,
    ST_LH,
    ST_HL,
    ST_HH,
    ST_DONE
  } rmul_state_t;

  localparam logic RMUL_EXACT  = 1'b0;
  localparam logic RMUL_APPROX = 1'b1;

  // Keeps bits [width-1:trunc]; callers narrow the result to their product width.
  function automatic logic [63:0] rmul_trunc_mask(input int width, input int trunc);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i >= trunc && i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rmul_half_core.sv
// Combinational HxH unsigned multiplier with optional LSB truncation of the product.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Time-shared by recursive_mult_seq across the four operand quadrants.
module rmul_half_core
  import rmul_pkg::*;
#(
  parameter int H     = 8,
  parameter int TRUNC = 4
) (
  input  logic [H-1:0]   x,
  input  logic [H-1:0]   y,
  input  logic           approx,
  output logic [2*H-1:0] p
);

  localparam logic [2*H-1:0] MASK = (2*H)'(rmul_trunc_mask(2 * H, TRUNC));

  logic [2*H-1:0] prod;

  assign prod = {{H{1'b0}}, x} * {{H{1'b0}}, y};
  assign p    = approx ? (prod & MASK) : prod;

endmodule

// File: rtl/recursive_mult_seq.sv
// Multi-cycle WxW multiplier: four half-width sub-products through one shared core, exact or approximate.
// Latency: 4 cycles from acceptance to out_valid; one transaction in flight, II >= 6.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. RMUL_ERR_DIST_EN adds err_dist.
module recursive_mult_seq
  import rmul_pkg::*;
#(
  parameter int W     = 16,
  parameter int TRUNC = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y
`ifdef RMUL_ERR_DIST_EN
  ,
  output logic [2*W-1:0] err_dist
`endif
);

  localparam int H = W / 2;

  rmul_state_t    state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic           mode_q;
  logic [2*W-1:0] acc;

  logic [H-1:0]   x_h;
  logic [H-1:0]   y_h;
  logic           approx_sel;
  logic [2*H-1:0] sub_p;
  logic [2*W-1:0] term;

  // Quadrant select and alignment; HH is never truncated.
  always_comb begin
    x_h        = a_q[H-1:0];
    y_h        = b_q[H-1:0];
    approx_sel = (mode_q == RMUL_APPROX);
    term       = (2*W)'(sub_p);
    case (state)
      ST_LH: begin
        y_h  = b_q[W-1:H];
        term = (2*W)'(sub_p) << H;
      end
      ST_HL: begin
        x_h  = a_q[W-1:H];
        term = (2*W)'(sub_p) << H;
      end
      ST_HH: begin
        x_h        = a_q[W-1:H];
        y_h        = b_q[W-1:H];
        approx_sel = 1'b0;
        term       = (2*W)'(sub_p) << W;
      end
      default: ;
    endcase
  end

  rmul_half_core #(
    .H     (H),
    .TRUNC (TRUNC)
  ) u_core (
    .x      (x_h),
    .y      (y_h),
    .approx (approx_sel),
    .p      (sub_p)
  );

`ifdef RMUL_ERR_DIST_EN
  logic [2*W-1:0] exact_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= RMUL_EXACT;
`ifdef RMUL_ERR_DIST_EN
      exact_q   <= '0;
      err_dist  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            mode_q   <= mode;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= ST_LL;
`ifdef RMUL_ERR_DIST_EN
            exact_q  <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
          end
        end
        ST_LL: begin
          acc   <= acc + term;
          state <= ST_LH;
        end
        ST_LH: begin
          acc   <= acc + term;
          state <= ST_HL;
        end
        ST_HL: begin
          acc   <= acc + term;
          state <= ST_HH;
        end
        ST_HH: begin
          acc       <= acc + term;
          out_valid <= 1'b1;
          state     <= ST_DONE;
`ifdef RMUL_ERR_DIST_EN
          err_dist  <= exact_q - (acc + term);
`endif
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The accumulator is only written outside DONE, so y is stable while offered.
  assign y = acc;

endmodule

// File: tb/tb_recursive_mult_seq.sv
// Directed and swept checks of recursive_mult_seq at W=16/TRUNC=4 and W=8/TRUNC=3.
// err_dist checks are compiled in when RMUL_ERR_DIST_EN is defined.
module tb_recursive_mult_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        in_valid16, in_ready16, mode16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] y16;
  logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] y8;
`ifdef RMUL_ERR_DIST_EN
  logic [31:0] err16;
  logic [15:0] err8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  recursive_mult_seq #(.W(16), .TRUNC(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16),
    .out_ready(out_ready16), .y(y16)
`ifdef RMUL_ERR_DIST_EN
    , .err_dist(err16)
`endif
  );

  recursive_mult_seq #(.W(8), .TRUNC(3)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8),
    .out_ready(out_ready8), .y(y8)
`ifdef RMUL_ERR_DIST_EN
    , .err_dist(err8)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent model: four quadrant products, truncation on all but HH.
  function automatic logic [63:0] ref_mul(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic m, input int w, input int tr);
    int h = w / 2;
    logic [63:0] mask, lo, al, ah, bl, bh, ll, lh, hl, hh;
    mask = ~64'd0 << tr;
    lo   = (64'd1 << h) - 64'd1;
    al = {32'd0, ra} & lo;
    ah = {32'd0, ra} >> h;
    bl = {32'd0, rb} & lo;
    bh = {32'd0, rb} >> h;
    ll = al * bl;
    lh = al * bh;
    hl = ah * bl;
    hh = ah * bh;
    if (m) begin
      ll = ll & mask;
      lh = lh & mask;
      hl = hl & mask;
    end
    return (hh << w) + ((lh + hl) << h) + ll;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair, count cycles from capture to out_valid, leave it in DONE.
  task automatic start16(input logic [15:0] ta, input logic [15:0] tb, input logic tm,
                         output int lat);
    a16 = ta; b16 = tb; mode16 = tm; in_valid16 = 1'b1;
    step();
    in_valid16 = 1'b0;
    a16 = 16'h0; b16 = 16'h0; mode16 = ~tm;
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic drain16();
    out_ready16 = 1'b1;
    step();
    out_ready16 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tm,
                      output int lat);
    a8 = ta; b8 = tb; mode8 = tm; in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    a8 = 8'h0; b8 = 8'h0;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] ra, rb, y_hold;
    logic rm;
    logic [63:0] expv;

    rst = 1'b1;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; mode16 = 1'b0;
    in_valid8  = 1'b0; out_ready8  = 1'b0; a8  = '0; b8  = '0; mode8  = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("reset_in_ready", 64'(in_ready16), 64'd1);
    chk("reset_out_valid", 64'(out_valid16), 64'd0);
    chk("reset_y", 64'(y16), 64'd0);
`ifdef RMUL_ERR_DIST_EN
    chk("reset_err_dist", 64'(err16), 64'd0);
`endif

    // Exact all-ones
    start16(16'hFFFF, 16'hFFFF, 1'b0, lat);
    chk("exact_ffff_latency", 64'(lat), 64'd4);
    chk("exact_ffff_y", 64'(y16), 64'hFFFE0001);
    chk("exact_ffff_in_ready", 64'(in_ready16), 64'd0);
`ifdef RMUL_ERR_DIST_EN
    chk("exact_ffff_err", 64'(err16), 64'd0);
`endif
    drain16();
    chk("drain_out_valid", 64'(out_valid16), 64'd0);
    chk("drain_in_ready", 64'(in_ready16), 64'd1);

    // Approximate all-ones
    start16(16'hFFFF, 16'hFFFF, 1'b1, lat);
    chk("approx_ffff_latency", 64'(lat), 64'd4);
    chk("approx_ffff_y", 64'(y16), 64'hFFFDFE00);
`ifdef RMUL_ERR_DIST_EN
    chk("approx_ffff_err", 64'(err16), 64'h201);
`endif
    drain16();

    // Small operands vanish entirely under truncation
    start16(16'd3, 16'd5, 1'b1, lat);
    chk("approx_3x5_y", 64'(y16), 64'd0);
`ifdef RMUL_ERR_DIST_EN
    chk("approx_3x5_err", 64'(err16), 64'd15);
`endif
    drain16();
    start16(16'd3, 16'd5, 1'b0, lat);
    chk("exact_3x5_y", 64'(y16), 64'd15);

    // Backpressure: hold DONE for 3 cycles with an in_valid pulse
    y_hold = y16;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        a16 = 16'h1234; b16 = 16'h5678; mode16 = 1'b0; in_valid16 = 1'b1;
      end
      step();
      in_valid16 = 1'b0;
      chk("bp_y_stable", 64'(y16), 64'(y_hold));
      chk("bp_in_ready_low", 64'(in_ready16), 64'd0);
      chk("bp_out_valid_high", 64'(out_valid16), 64'd1);
    end
    drain16();
    chk("bp_release_out_valid", 64'(out_valid16), 64'd0);
    chk("bp_release_in_ready", 64'(in_ready16), 64'd1);
    chk("bp_y_after_release", 64'(y16), 64'd15);

    // Reset while in LH aborts the transaction
    a16 = 16'hABCD; b16 = 16'h1357; mode16 = 1'b0; in_valid16 = 1'b1;
    step();
    in_valid16 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_lh_out_valid", 64'(out_valid16), 64'd0);
    chk("rst_lh_in_ready", 64'(in_ready16), 64'd1);
    chk("rst_lh_y", 64'(y16), 64'd0);
    start16(16'd2, 16'd7, 1'b0, lat);
    chk("post_rst_latency", 64'(lat), 64'd4);
    chk("post_rst_y", 64'(y16), 64'd14);
    drain16();

    // Random sweep, both widths, both modes
    for (int i = 0; i < 24; i++) begin
      ra = $urandom & 32'hFFFF;
      rb = $urandom & 32'hFFFF;
      rm = 1'($urandom_range(0, 1));
      start16(ra[15:0], rb[15:0], rm, lat);
      expv = ref_mul(ra, rb, rm, 16, 4);
      chk(rm ? "sweep16_approx_y" : "sweep16_exact_y", 64'(y16), expv);
      chk("sweep16_latency", 64'(lat), 64'd4);
`ifdef RMUL_ERR_DIST_EN
      chk("sweep16_err", 64'(err16), ((ra * rb) & 64'hFFFFFFFF) - expv);
`endif
      drain16();
    end

    for (int i = 0; i < 24; i++) begin
      ra = $urandom & 32'hFF;
      rb = $urandom & 32'hFF;
      rm = 1'($urandom_range(0, 1));
      run8(ra[7:0], rb[7:0], rm, lat);
      expv = ref_mul(ra, rb, rm, 8, 3);
      chk(rm ? "sweep8_approx_y" : "sweep8_exact_y", 64'(y8), expv);
      chk("sweep8_latency", 64'(lat), 64'd4);
`ifdef RMUL_ERR_DIST_EN
      chk("sweep8_err", 64'(err8), ((ra * rb) & 64'hFFFF) - expv);
`endif
      out_ready8 = 1'b1;
      step();
      out_ready8 = 1'b0;
      chk("sweep8_in_ready", 64'(in_ready8), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/recursive_mult_seq.md
# recursive_mult_seq

Parametrised, multi-cycle successor to the 16-bit recursive approximate multiplier. It computes a W×W unsigned product by splitting each operand into high and low halves and running the four (W/2)×(W/2) sub-products through one shared half-width core, one per cycle, with shifted accumulation. A per-transaction mode selects exact or approximate sub-products. Valid/ready handshakes on both sides let it sit between pipeline stages of the approximate-arithmetic datapath.

## Interface
Parameters:
- W, 16, operand width; even, ≥ 8
- TRUNC, 4, number of LSBs cleared in approximate sub-products; 0 ≤ TRUNC < W

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block can accept a transaction
- a  in  W  multiplicand, unsigned
- b  in  W  multiplier, unsigned
- mode  in  1  0 = exact, 1 = approximate; captured with the operands
- out_valid  out  1  y holds a finished product
- out_ready  in  1  consumer accepts y
- y  out  2W  product
- err_dist  out  2W  exact product minus y; present only with RMUL_ERR_DIST_EN

## Operation
- Split: H = W/2. aL = a[H-1:0], aH = a[W-1:H]; b is split the same way.
- Sub-product P = x·y is full 2H bits wide, with no truncation of width.
- Exact mode: every sub-product is exact.
- Approximate mode: the LL, LH and HL sub-products have bits [TRUNC-1:0] forced to 0. HH is always exact.
- Accumulation: y = HH<<W + LH<<H + HL<<H + LL, using a 2W-bit accumulator.
  - No overflow is possible, because approximate y ≤ exact product.
- FSM states: IDLE, LL, LH, HL, HH, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, capture a, b and mode, clear the accumulator, and go to LL.
  - LL / LH / HL / HH: add the shifted term on the closing edge, then advance. HH goes to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- in_valid outside IDLE is ignored. Operands and mode are changeable once the capture edge has passed.
- y and err_dist are held stable throughout DONE, whatever happens on the input side.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, y = 0, err_dist = 0, accumulator = 0.
- Reset in any state, including mid-computation or DONE, aborts the transaction with no output.

## Timing
- Capture edge = cycle 0. Term edges fall on cycles 1–4, and out_valid is high from cycle 4 onward.
- Latency is 4 cycles from acceptance to out_valid.
- Minimum initiation interval is 6 cycles: accept, LL, LH, HL, HH, DONE with out_ready high, then IDLE.
- in_ready and out_valid are never high in the same cycle.
- out_valid drops on the edge after out_valid & out_ready.

## Configuration
- RMUL_ERR_DIST_EN defined:
  - A behavioural W×W exact product of the captured operands is registered.
  - err_dist = exact − y, valid whenever out_valid is high.
  - err_dist is 0 in exact mode.
- RMUL_ERR_DIST_EN undefined: the err_dist port and its logic are absent, and no exact multiplier is built.

## Structure
- Shared package rmul_pkg:
  - FSM state enum
  - mode encoding constants RMUL_EXACT / RMUL_APPROX
  - a function returning the truncation mask for a given width and TRUNC
- One sub-module, rmul_half_core:
  - combinational H×H multiplier
  - `approx` input applies the TRUNC mask
  - instantiated once and time-shared across the four quadrants
- Operand half-select and shift amount are muxed by FSM state.

## Test plan
- W=16, exact: a=0xFFFF, b=0xFFFF → y=0xFFFE0001 with out_valid on cycle 4. With the macro, err_dist=0.
- W=16, TRUNC=4, approximate: a=0xFFFF, b=0xFFFF → y=0xFFFDFE00, err_dist=0x201.
- Approximate: a=3, b=5 → y=0, err_dist=15. The same operands in exact mode → y=15.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → y stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 → IDLE next cycle.
- Reset in state LH → next cycle out_valid=0, in_ready=1, y=0. A fresh a=2, b=7 then yields 14.
- Random sweep, W=8 and W=16, both modes → exact mode matches a·b, and approximate mode matches the reference model of the truncated quadrants.
